// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and types for the 7-segment scan driver and
//               the lock-status display: digit count, scan states, hex to
//               segment lookup table and the blank pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  // Scan sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } seg_state_e;

  // Blank pattern, active-high segments {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Hex code to segments {g,f,e,d,c,b,a}; entry n is SEG7_LUT[n]
  localparam logic [15:0][6:0] SEG7_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Apply panel polarity: common-anode panels want inverted segments
  function automatic logic [6:0] seg_polarity(input logic [6:0] s, input logic inv);
    return inv ? ~s : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg7
// Description : Combinational 4-bit hex code to 7-segment decoder, active-high
//               segment lines {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for the code
  always_comb begin
    seg = SEG7_LUT[code];
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_6.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_6
// Description : Six-digit multiplexed 7-segment display driver. A prescaler
//               produces the per-digit scan tick; a sequencer walks the six
//               slots, inserting GAP_CYC dark cycles between digits. All
//               panel outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_6
  import seg_pkg::*;
#(
  parameter int DIV     = 8,
  parameter int GAP_CYC = 2,
  parameter bit SEG_INV = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] digits,
  input  logic [5:0]  dp,
  input  logic [5:0]  blank,
  output logic [6:0]  seg,
  output logic        seg_dp,
  output logic [5:0]  com,
  output logic [2:0]  digit_idx
);

  localparam int PW = $clog2(DIV);
  localparam int GW = $clog2(GAP_CYC + 1);

  localparam logic [PW-1:0] C_DIV_LAST = PW'(DIV - 1);
  localparam logic [GW-1:0] C_GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [2:0]    C_IDX_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [6:0]    C_SEG_DARK = SEG_INV ? 7'h7F : SEG_OFF;
  localparam logic          C_DP_DARK  = SEG_INV;

  seg_state_e    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [GW-1:0] gap_q,   gap_d;
  logic [2:0]    next_q,  next_d;
  logic [2:0]    idx_q,   idx_d;
  logic [5:0]    com_q,   com_d;
  logic [6:0]    seg_q,   seg_d;
  logic          dp_q,    dp_d;

  logic          tick;
  logic [3:0]    sel_code;
  logic          sel_dp;
  logic          sel_blank;
  logic [6:0]    sel_seg;

  assign tick = en & (presc_q == C_DIV_LAST);

  // Pick the code, dp and blank bits of the slot currently being scanned
  always_comb begin
    sel_code  = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        sel_code  = digits[4*i +: 4];
        sel_dp    = dp[i];
        sel_blank = blank[i];
      end
    end
  end

  hex_to_seg7 u_dec (
    .code (sel_code),
    .seg  (sel_seg)
  );

  // Prescaler, sequencer and output-register next values
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    gap_d   = gap_q;
    next_d  = next_q;
    idx_d   = idx_q;
    com_d   = com_q;
    seg_d   = seg_q;
    dp_d    = dp_q;

    if (!en) begin
      // Disabled: park dark, restart from slot 0 when re-enabled
      state_d = IDLE;
      presc_d = '0;
      gap_d   = '0;
      next_d  = 3'd0;
      com_d   = 6'b0;
      seg_d   = C_SEG_DARK;
      dp_d    = C_DP_DARK;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      case (state_q)
        IDLE, SHOW: begin
          if (tick) begin
            state_d = GAP;
            gap_d   = '0;
            idx_d   = next_q;
            next_d  = (next_q == C_IDX_LAST) ? 3'd0 : next_q + 3'd1;
            com_d   = 6'b0;
            seg_d   = C_SEG_DARK;
            dp_d    = C_DP_DARK;
          end
        end
        GAP: begin
          if (gap_q == C_GAP_LAST) begin
            // Inputs are sampled only here, so mid-SHOW changes wait a visit
            state_d = SHOW;
            gap_d   = '0;
            if (!sel_blank) begin
              com_d = 6'b000001 << idx_q;
              seg_d = seg_polarity(sel_seg, SEG_INV);
              dp_d  = sel_dp ^ SEG_INV;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          com_d   = 6'b0;
          seg_d   = C_SEG_DARK;
          dp_d    = C_DP_DARK;
        end
      endcase
    end
  end

  // State and output registers, asynchronously reset dark
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      gap_q   <= '0;
      next_q  <= 3'd0;
      idx_q   <= 3'd0;
      com_q   <= 6'b0;
      seg_q   <= C_SEG_DARK;
      dp_q    <= C_DP_DARK;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      gap_q   <= gap_d;
      next_q  <= next_d;
      idx_q   <= idx_d;
      com_q   <= com_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign seg       = seg_q;
  assign seg_dp    = dp_q;
  assign com       = com_q;
  assign digit_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_6.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_6
// Description : Directed bench for seg_scan_6 (DIV=8, GAP_CYC=2) with a
//               normal-polarity and an inverted-polarity instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [23:0] digits = 24'h0;
  logic [5:0]  dp = 6'h0;
  logic [5:0]  blank = 6'h0;

  logic [6:0]  seg,   seg_i;
  logic        seg_dp, seg_dp_i;
  logic [5:0]  com,   com_i;
  logic [2:0]  digit_idx, digit_idx_i;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cur_edge = 0;

  typedef struct {
    int         edge_n;
    logic [5:0] com;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
  } chk_t;

  chk_t tbl[$];

  always #5 clk = ~clk;

  seg_scan_6 #(.DIV(8), .GAP_CYC(2), .SEG_INV(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp), .blank(blank),
    .seg(seg), .seg_dp(seg_dp), .com(com), .digit_idx(digit_idx)
  );

  seg_scan_6 #(.DIV(8), .GAP_CYC(2), .SEG_INV(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp), .blank(blank),
    .seg(seg_i), .seg_dp(seg_dp_i), .com(com_i), .digit_idx(digit_idx_i)
  );

  // com must never have more than one bit set
  always @(negedge clk) begin
    cmp_cnt++;
    if ($countones(com) > 1 || $countones(com_i) > 1) begin
      err_cnt++;
      $display("FAIL onehot @%0t: com=%b com_inv=%b, need at most one bit", $time, com, com_i);
    end
  end

  task automatic goto_edge(input int e);
    while (cur_edge < e) begin
      @(posedge clk);
      #1;
      cur_edge++;
    end
  endtask

  task automatic restart();
    en = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b1;
    cur_edge = 0;
  endtask

  task automatic check_main(input string nm, input logic [5:0] ecom, input logic [6:0] eseg,
                            input logic edp, input logic [2:0] eidx);
    cmp_cnt++;
    if ({com, seg, seg_dp, digit_idx} !== {ecom, eseg, edp, eidx}) begin
      err_cnt++;
      $display("FAIL %s: got com=%b seg=%h dp=%b idx=%0d, need com=%b seg=%h dp=%b idx=%0d",
               nm, com, seg, seg_dp, digit_idx, ecom, eseg, edp, eidx);
    end
  endtask

  task automatic check_inv(input string nm, input logic [5:0] ecom, input logic [6:0] eseg,
                           input logic edp);
    cmp_cnt++;
    if ({com_i, seg_i, seg_dp_i} !== {ecom, eseg, edp}) begin
      err_cnt++;
      $display("FAIL %s: got com=%b seg=%h dp=%b, need com=%b seg=%h dp=%b",
               nm, com_i, seg_i, seg_dp_i, ecom, eseg, edp);
    end
  endtask

  task automatic run_tbl(input string phase);
    for (int i = 0; i < tbl.size(); i++) begin
      goto_edge(tbl[i].edge_n);
      check_main($sformatf("%s[%0d]@e%0d", phase, i, tbl[i].edge_n),
                 tbl[i].com, tbl[i].seg, tbl[i].dp, tbl[i].idx);
    end
    tbl.delete();
  endtask

  initial begin
    // ---------------- reset ----------------
    #2 rst = 1'b0;
    #10;
    check_main("reset", 6'b0, 7'h00, 1'b0, 3'd0);
    check_inv("reset_inv", 6'b0, 7'h7F, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    digits = 24'h543210;
    en = 1'b1;
    cur_edge = 0;

    // ---------------- basic scan, digits 543210 ----------------
    tbl.push_back('{9,  6'b000000, 7'h00, 1'b0, 3'd0});
    tbl.push_back('{10, 6'b000001, 7'h3F, 1'b0, 3'd0});
    tbl.push_back('{15, 6'b000001, 7'h3F, 1'b0, 3'd0});
    tbl.push_back('{16, 6'b000000, 7'h00, 1'b0, 3'd1});
    tbl.push_back('{17, 6'b000000, 7'h00, 1'b0, 3'd1});
    tbl.push_back('{18, 6'b000010, 7'h06, 1'b0, 3'd1});
    tbl.push_back('{26, 6'b000100, 7'h5B, 1'b0, 3'd2});
    tbl.push_back('{58, 6'b000001, 7'h3F, 1'b0, 3'd0});
    run_tbl("basic");

    // ---------------- codes A..F, full rotation ----------------
    digits = 24'hFEDCBA;
    restart();
    tbl.push_back('{10, 6'b000001, 7'h77, 1'b0, 3'd0});
    tbl.push_back('{18, 6'b000010, 7'h7C, 1'b0, 3'd1});
    tbl.push_back('{26, 6'b000100, 7'h39, 1'b0, 3'd2});
    tbl.push_back('{34, 6'b001000, 7'h5E, 1'b0, 3'd3});
    tbl.push_back('{42, 6'b010000, 7'h79, 1'b0, 3'd4});
    tbl.push_back('{50, 6'b100000, 7'h71, 1'b0, 3'd5});
    tbl.push_back('{56, 6'b000000, 7'h00, 1'b0, 3'd0});
    tbl.push_back('{58, 6'b000001, 7'h77, 1'b0, 3'd0});
    run_tbl("hexAF");

    // ---------------- blanking and decimal point ----------------
    digits = 24'h543210;
    blank  = 6'b000100;
    dp     = 6'b100000;
    restart();
    tbl.push_back('{18, 6'b000010, 7'h06, 1'b0, 3'd1});
    tbl.push_back('{26, 6'b000000, 7'h00, 1'b0, 3'd2});
    tbl.push_back('{29, 6'b000000, 7'h00, 1'b0, 3'd2});
    tbl.push_back('{31, 6'b000000, 7'h00, 1'b0, 3'd2});
    tbl.push_back('{34, 6'b001000, 7'h4F, 1'b0, 3'd3});
    tbl.push_back('{50, 6'b100000, 7'h6D, 1'b1, 3'd5});
    tbl.push_back('{56, 6'b000000, 7'h00, 1'b0, 3'd0});
    run_tbl("blankdp");
    blank = 6'b0;
    dp    = 6'b0;

    // ---------------- input change during SHOW ----------------
    digits = 24'h543211;
    restart();
    goto_edge(12);
    check_main("midshow_before", 6'b000001, 7'h06, 1'b0, 3'd0);
    digits[3:0] = 4'h8;
    goto_edge(15);
    check_main("midshow_hold", 6'b000001, 7'h06, 1'b0, 3'd0);
    goto_edge(58);
    check_main("midshow_next", 6'b000001, 7'h7F, 1'b0, 3'd0);

    // ---------------- en drop during slot 3 ----------------
    digits = 24'h543210;
    restart();
    goto_edge(36);
    check_main("endrop_show3", 6'b001000, 7'h4F, 1'b0, 3'd3);
    en = 1'b0;
    @(posedge clk);
    #1;
    check_main("endrop_dark", 6'b000000, 7'h00, 1'b0, 3'd3);
    en = 1'b1;
    cur_edge = 0;
    goto_edge(9);
    check_main("endrop_gap0", 6'b000000, 7'h00, 1'b0, 3'd0);
    goto_edge(10);
    check_main("endrop_slot0", 6'b000001, 7'h3F, 1'b0, 3'd0);

    // ---------------- async reset mid-gap, both polarities ----------------
    restart();
    goto_edge(10);
    check_inv("inv_show0", 6'b000001, 7'h40, 1'b1);
    goto_edge(16);
    check_main("gap1", 6'b000000, 7'h00, 1'b0, 3'd1);
    check_inv("inv_gap1", 6'b000000, 7'h7F, 1'b1);
    #3 rst = 1'b0;
    #1;
    check_main("async_rst", 6'b000000, 7'h00, 1'b0, 3'd0);
    check_inv("async_rst_inv", 6'b000000, 7'h7F, 1'b1);
    @(posedge clk);
    #1;
    check_main("rst_held", 6'b000000, 7'h00, 1'b0, 3'd0);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_6.md
Name: seg_scan_6

Overview:
- Six-digit multiplexed 7-segment display driver for the doorlock front panel.
- Contains a prescaler that generates the scan tick and a mod-6 digit sequencer that steps through the six digits.
- Each digit is decoded from a 4-bit hex code to segment lines and driven onto a one-hot common-select bus.
- Inserts a programmable dead-time gap between digits to suppress ghosting.
- Consumes the six 4-bit digit codes produced by the upstream entry/counter logic and drives the FPGA display pins directly.

Parameters:
- DIV, 8, scan period in clk cycles per digit; legal range is DIV >= GAP_CYC+2.
- GAP_CYC, 2, number of clk cycles during which com and seg are all-zero between digits; legal range is GAP_CYC >= 1.
- SEG_INV, 0, when 1, seg and seg_dp are inverted at the output register (for common-anode panels).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  scan enable.
- digits  in  24  six 4-bit hex codes; digit n occupies bits [4n+3:4n].
- dp  in  6  decimal-point request per digit.
- blank  in  6  per-digit blanking; 1 means the digit slot is dark.
- seg  out  7  segment lines {g,f,e,d,c,b,a}, registered, active-high before SEG_INV.
- seg_dp  out  1  decimal-point segment, registered.
- com  out  6  one-hot digit select, active-high, registered.
- digit_idx  out  3  index 0..5 of the slot currently scanned, registered.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, prescaler=0, gap counter=0, next pointer=0, digit_idx=0, com=0, seg=0, seg_dp=0. With SEG_INV=1, seg and seg_dp reset to all-ones, i.e. dark.
- A reset mid-scan aborts immediately; there is no partial digit.
- Prescaler:
  - While en=1 it counts 0..DIV-1 and wraps to 0.
  - tick is combinational: tick = en & (prescaler==DIV-1).
  - While en=0 the prescaler clears to 0.
- FSM states:
  - IDLE: com=0, seg dark. Goes to GAP on tick.
  - GAP: com=0, seg dark. Lasts exactly GAP_CYC cycles, then goes to SHOW.
  - SHOW: com and seg show the selected digit. Goes to GAP on tick.
- On tick (entering GAP): digit_idx <= next pointer; next pointer <= (next==5) ? 0 : next+1. The pointer wraps 5→0.
- Sampling: digits[digit_idx], dp[digit_idx] and blank[digit_idx] are sampled on the edge that enters SHOW. Input changes during SHOW take effect on the next visit to that slot.
- On entering SHOW:
  - If blank=0: com = 1<<digit_idx, seg = decode(code), seg_dp = dp bit.
  - If blank=1: com=0 and seg stays dark. The slot still consumes its time and the pointer still advances.
- Decode table, {g..a} in hex, for codes 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- en falling: on the next edge, state=IDLE, com=0, seg dark, next pointer=0, prescaler=0. When en rises again, scanning restarts at digit 0.
- Latency:
  - Take edge 1 as the first edge that samples en=1 after an IDLE restart.
  - tick occurs in the cycle after edge DIV-1. GAP is entered at edge DIV. SHOW for digit 0 is entered at edge DIV+GAP_CYC.
  - Each digit then occupies exactly DIV cycles: GAP_CYC dark cycles plus DIV-GAP_CYC lit cycles.
- Invariants:
  - com is never more than one-hot.
  - com is all-zero in IDLE and GAP.

Decomposition:
- Shared package seg_pkg holds:
  - NUM_DIGITS=6;
  - the state enum {IDLE, GAP, SHOW};
  - the 16-entry SEG7_LUT constant;
  - the blank-pattern constant SEG_OFF=7'h00.
- One combinational sub-module, hex_to_seg7, maps a 4-bit code to 7 segment bits via SEG7_LUT. It is reused by the lock-status display.

Test Plan:
1. Reset, then en=1, DIV=8, GAP_CYC=2, digits=24'h543210, dp=0, blank=0 -> com=6'b000001 and seg=7'h3F first at edge 10. At edge 16 com=0 (gap). At edge 18 com=6'b000010 and seg=7'h06.
2. Run 6 full slots with digits=24'hFEDCBA -> seg sequence 77 7C 39 5E 79 71. After slot 5, digit_idx wraps to 0 and com returns to 000001.
3. blank=6'b000100, dp=6'b100000 -> slot 2 keeps com=0 for its full 8 cycles. Slot 5 shows seg_dp=1. All other seg_dp=0.
4. Change digits[3:0] from 4'h1 to 4'h8 during slot-0 SHOW -> slot-0 seg stays 06 for that visit and becomes 7F on the next visit.
5. Drop en during SHOW of slot 3 -> com=0 on the next edge. Re-raise en -> slot 0 appears DIV+GAP_CYC edges later.
6. Assert rst mid-GAP, asynchronously between edges -> all outputs reach reset values immediately. Repeat with SEG_INV=1 -> seg=7'h7F and seg_dp=1 during reset and gaps.
